dec_bist_sweeper: RTL and testbench

//   Built-in self-test controller for the 4x16 decoder (dec_4x16 and its fault-injected variants).

---
 rtl/dec_bist_pkg.sv | 15 +
 rtl/dec_bist_compare.sv | 16 +
 rtl/dec_bist_sweeper.sv | 105 ++++++++++
 tb/tb_dec_bist_sweeper.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dec_bist_pkg.sv
// Shared types and sizes for the 4x16 decoder BIST sweepers.
// Pure declarations: no latency, no flow control.
package dec_bist_pkg;

  localparam int ADDR_W = 4;
  localparam int OUT_W  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } bist_state_t;

endpackage

// File: rtl/dec_bist_compare.sv
// Expected one-hot pattern for a select code and mismatch against the observed outputs.
// Combinational, zero latency; no backpressure.
module dec_bist_compare
  import dec_bist_pkg::*;
(
  input  logic [ADDR_W-1:0] code,
  input  logic [OUT_W-1:0]  d,
  output logic [OUT_W-1:0]  exp_d,
  output logic              mismatch
);

  assign exp_d    = OUT_W'(1) << code;
  // Any deviation counts: zero-hot, multi-hot and a misplaced single bit.
  assign mismatch = (d != exp_d);

endmodule

// File: rtl/dec_bist_sweeper.sv
// Sweeps decoder selects through all 16 codes, checks D per code, accumulates a fault summary.
// Latency: 16*(SETTLE+1) cycles from start to done; start is ignored while busy (no backpressure).
module dec_bist_sweeper
  import dec_bist_pkg::*;
#(
  parameter int SETTLE = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [OUT_W-1:0]  D,
  output logic              X,
  output logic              Y,
  output logic              Z,
  output logic              W,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [4:0]        fault_cnt,
  output logic [OUT_W-1:0]  fault_map,
  output logic [ADDR_W-1:0] first_fail_addr,
  output logic              first_fail_valid
);

  localparam logic [3:0]        CNT_LAST  = 4'(SETTLE - 1);
  localparam logic [ADDR_W-1:0] CODE_LAST = {ADDR_W{1'b1}};

  bist_state_t       state, state_nxt;
  logic [ADDR_W-1:0] code;
  logic [3:0]        cnt;
  logic [OUT_W-1:0]  exp_d;
  logic              mismatch;

  dec_bist_compare u_compare (
    .code     (code),
    .d        (D),
    .exp_d    (exp_d),
    .mismatch (mismatch)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = WAIT;
      WAIT:       if (cnt == CNT_LAST) state_nxt = CHECK;
      CHECK:      state_nxt = (code == CODE_LAST) ? DONE : WAIT;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code             <= '0;
      cnt              <= '0;
      fault_cnt        <= '0;
      fault_map        <= '0;
      first_fail_addr  <= '0;
      first_fail_valid <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            code             <= '0;
            cnt              <= '0;
            fault_cnt        <= '0;
            fault_map        <= '0;
            first_fail_addr  <= '0;
            first_fail_valid <= 1'b0;
          end
        end
        WAIT: cnt <= cnt + 4'd1;
        CHECK: begin
          if (mismatch) begin
            fault_cnt       <= fault_cnt + 5'd1;
            fault_map[code] <= 1'b1;
            if (!first_fail_valid) begin
              first_fail_addr  <= code;
              first_fail_valid <= 1'b1;
            end
          end
          // Code stays at 15 on the last check so DONE presents it.
          if (code != CODE_LAST) begin
            code <= code + 1'b1;
            cnt  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign {X, Y, Z, W} = code;
  assign busy         = (state == WAIT) || (state == CHECK);
  assign done         = (state == DONE);
  assign pass         = done && (fault_cnt == 5'd0);

  logic unused_exp;
  assign unused_exp = ^exp_d;

endmodule

// File: tb/tb_dec_bist_sweeper.sv
// Bench for dec_bist_sweeper: two instances (SETTLE=2 with selectable decoder faults, SETTLE=1 golden).
// Sweep results are queued at start and compared by per-instance monitors when done rises.
module tb_dec_bist_sweeper;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic [15:0] d_a, d_b;
  logic        x_a, y_a, z_a, w_a, busy_a, done_a, pass_a, ffv_a;
  logic        x_b, y_b, z_b, w_b, busy_b, done_b, pass_b, ffv_b;
  logic [4:0]  fcnt_a, fcnt_b;
  logic [15:0] fmap_a, fmap_b;
  logic [3:0]  ffa_a, ffa_b, code_a, code_b;

  int n_chk = 0, n_fail = 0;
  int cyc = 0;
  int start_cyc_a = 0, start_cyc_b = 0;
  int fault_mode = 0;   // 0 golden, 1 D[5] stuck-at-0, 2 D[0] stuck-at-1

  typedef struct {
    int          edges;
    logic        pass;
    logic [4:0]  fcnt;
    logic [15:0] fmap;
    logic [3:0]  ffa;
    logic        ffv;
  } exp_t;

  exp_t q_a[$], q_b[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign code_a = {x_a, y_a, z_a, w_a};
  assign code_b = {x_b, y_b, z_b, w_b};

  always_comb begin
    d_a = 16'h0001 << code_a;
    if (fault_mode == 1) d_a[5] = 1'b0;
    if (fault_mode == 2) d_a[0] = 1'b1;
  end
  assign d_b = 16'h0001 << code_b;

  dec_bist_sweeper #(.SETTLE(2)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .D(d_a),
    .X(x_a), .Y(y_a), .Z(z_a), .W(w_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .fault_cnt(fcnt_a), .fault_map(fmap_a), .first_fail_addr(ffa_a), .first_fail_valid(ffv_a)
  );

  dec_bist_sweeper #(.SETTLE(1)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .D(d_b),
    .X(x_b), .Y(y_b), .Z(z_b), .W(w_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .fault_cnt(fcnt_b), .fault_map(fmap_b), .first_fail_addr(ffa_b), .first_fail_valid(ffv_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic push_a(input logic p, input logic [4:0] fc, input logic [15:0] fm,
                        input logic [3:0] fa, input logic fv);
    exp_t e;
    e.edges = 48; e.pass = p; e.fcnt = fc; e.fmap = fm; e.ffa = fa; e.ffv = fv;
    q_a.push_back(e);
  endtask

  // Start goes high at a negedge; the following posedge is edge 0 of the sweep.
  task automatic pulse_a();
    @(negedge clk);
    start_a = 1'b1;
    start_cyc_a = cyc + 1;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic pulse_b();
    @(negedge clk);
    start_b = 1'b1;
    start_cyc_b = cyc + 1;
    @(negedge clk);
    start_b = 1'b0;
  endtask

  task automatic wait_done_a();
    int k = 0;
    while (!done_a && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (!done_a) begin
      n_chk++; n_fail++;
      $display("FAIL a_done_timeout: done still %0b after %0d cycles", done_a, k);
    end
    @(negedge clk);
    check("a_queue_drained", q_a.size(), 0);
  endtask

  // Monitors: compare a queued result whenever done rises.
  logic done_a_q = 1'b0, done_b_q = 1'b0;

  always @(negedge clk) begin
    if (done_a && !done_a_q) begin
      if (q_a.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL a_unexpected_done: done=1 at edge %0d, required no result", cyc - start_cyc_a);
      end else begin
        exp_t e;
        e = q_a.pop_front();
        check("a_done_edge", cyc - start_cyc_a, e.edges);
        check("a_pass", pass_a, e.pass);
        check("a_fault_cnt", fcnt_a, e.fcnt);
        check("a_fault_map", fmap_a, e.fmap);
        check("a_first_fail_valid", ffv_a, e.ffv);
        if (e.ffv) check("a_first_fail_addr", ffa_a, e.ffa);
        check("a_code_in_done", code_a, 15);
        check("a_busy_in_done", busy_a, 0);
      end
    end
    done_a_q = done_a;
  end

  always @(negedge clk) begin
    if (done_b && !done_b_q) begin
      if (q_b.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL b_unexpected_done: done=1 at edge %0d, required no result", cyc - start_cyc_b);
      end else begin
        exp_t e;
        e = q_b.pop_front();
        check("b_done_edge", cyc - start_cyc_b, e.edges);
        check("b_pass", pass_b, e.pass);
        check("b_fault_cnt", fcnt_b, e.fcnt);
        check("b_fault_map", fmap_b, e.fmap);
        check("b_first_fail_valid", ffv_b, e.ffv);
      end
    end
    done_b_q = done_b;
  end

  task automatic check_all_zero_a(input string tag);
    check({tag, "_xyzw"}, code_a, 0);
    check({tag, "_busy"}, busy_a, 0);
    check({tag, "_done"}, done_a, 0);
    check({tag, "_pass"}, pass_a, 0);
    check({tag, "_fault_cnt"}, fcnt_a, 0);
    check({tag, "_fault_map"}, fmap_a, 0);
    check({tag, "_ffa"}, ffa_a, 0);
    check({tag, "_ffv"}, ffv_a, 0);
  endtask

  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    repeat (3) @(negedge clk);
    check_all_zero_a("reset");
    check("reset_b_done", done_b, 0);
    rst = 1'b0;
    @(negedge clk);

    // Golden decoder.
    fault_mode = 0;
    push_a(1'b1, 5'd0, 16'h0000, 4'd0, 1'b0);
    pulse_a();
    check("t1_busy_after_start", busy_a, 1);
    wait_done_a();

    // D[5] stuck-at-0, with ignored start pulses at edges 10 and 30.
    fault_mode = 1;
    push_a(1'b0, 5'd1, 16'h0020, 4'd5, 1'b1);
    pulse_a();
    repeat (9) @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    check("t5_code_after_edge10", code_a, 3);
    repeat (19) @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    check("t5_code_after_edge30", code_a, 10);
    check("t5_busy_after_edge30", busy_a, 1);
    wait_done_a();

    // Restart from DONE clears the previous results.
    fault_mode = 0;
    check("t5_map_held_in_done", fmap_a, 16'h0020);
    push_a(1'b1, 5'd0, 16'h0000, 4'd0, 1'b0);
    pulse_a();
    check("t5_restart_busy", busy_a, 1);
    check("t5_restart_done", done_a, 0);
    check("t5_restart_code", code_a, 0);
    check("t5_restart_fault_cnt", fcnt_a, 0);
    check("t5_restart_fault_map", fmap_a, 0);
    check("t5_restart_ffv", ffv_a, 0);
    wait_done_a();

    // D[0] stuck-at-1: only code 0 matches.
    fault_mode = 2;
    push_a(1'b0, 5'd15, 16'hFFFE, 4'd1, 1'b1);
    pulse_a();
    wait_done_a();

    // Reset at edge 20 of a faulty sweep, then a clean golden sweep.
    pulse_a();
    repeat (19) @(negedge clk);
    check("t4_fault_cnt_before_rst", fcnt_a, 5);
    @(posedge clk);
    #1 rst = 1'b1;
    #1 check_all_zero_a("t4_rst");
    @(negedge clk);
    rst = 1'b0;
    fault_mode = 0;
    push_a(1'b1, 5'd0, 16'h0000, 4'd0, 1'b0);
    pulse_a();
    wait_done_a();

    // SETTLE=1: each code held for 2 cycles, done at edge 32.
    begin
      exp_t e;
      e.edges = 32; e.pass = 1'b1; e.fcnt = 5'd0; e.fmap = 16'h0000; e.ffa = 4'd0; e.ffv = 1'b0;
      q_b.push_back(e);
    end
    pulse_b();
    for (int k = 0; k < 32; k++) begin
      check($sformatf("t6_code_edge%0d", k), code_b, k / 2);
      if (!busy_b) check($sformatf("t6_busy_edge%0d", k), busy_b, 1);
      @(negedge clk);
    end
    @(negedge clk);
    check("b_queue_drained", q_b.size(), 0);
    check("t6_done_level", done_b, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
